load_queue: RTL and testbench
=============================

# load_queue

In-order load queue sitting beside the store queue in the memory stage. It allocates an entry per dispatched load and captures the address from the AGU. It issues loads to the data-memory read port one at a time in program order and returns load data to writeback. Entries retire on ROB commit, and the whole queue clears on pipeline flush.

## Interface
- LQ_SIZE, 8, entries; power of two, at least 2
- ADDR_WIDTH, 32, address bits
- DATA_WIDTH, 32, data bits
- ROB_SEL, 6, ROB index bits
- PREG_SEL, 6, destination physical register bits
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- dispatch_valid  in  1  new load offered
- dispatch_rob_idx  in  ROB_SEL  ROB index of the load
- dispatch_dst_preg  in  PREG_SEL  destination register
- dispatch_lq_idx  out  log2(LQ_SIZE)  tail index; valid when the load is accepted
- addr_valid  in  1  AGU address update
- addr_lq_idx  in  log2(LQ_SIZE)  entry to update
- addr_value  in  ADDR_WIDTH  computed address
- mem_req_valid  out  1  read request to data memory
- mem_req_addr  out  ADDR_WIDTH  request address
- mem_req_ready  in  1  memory accepts the request
- mem_resp_valid  in  1  read data returned
- mem_resp_data  in  DATA_WIDTH  read data
- wb_valid  out  1  one-cycle writeback pulse
- wb_rob_idx  out  ROB_SEL  ROB index of the load being written back
- wb_dst_preg  out  PREG_SEL  destination register of the load being written back
- wb_data  out  DATA_WIDTH  load data
- commit_valid  in  1  retire the head entry
- flush  in  1  discard all entries
- lq_full  out  1  count == LQ_SIZE
- lq_empty  out  1  count == 0
- lq_count  out  log2(LQ_SIZE)+1  occupied entries

## Operation
- Each entry holds:
  - valid, rob_idx, dst_preg, addr, addr_rdy, issued, done.
- Pointers:
  - head, tail, and issue pointer iptr, each log2(LQ_SIZE) bits; wrap modulo LQ_SIZE.
  - count is LQ_SIZE-capable.
- Dispatch:
  - Accepted iff dispatch_valid && !lq_full.
  - Writes the entry at tail with addr_rdy = issued = done = 0, then increments tail.
  - dispatch_lq_idx is combinationally equal to tail.
- Address update:
  - Applied iff the target entry is valid && !issued. Sets addr and addr_rdy.
  - Otherwise ignored. An update aimed at the entry being dispatched in the same cycle is ignored.
- Issue FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE → REQ when the entry at iptr is valid && addr_rdy && !issued. Latch mem_req_addr from that entry.
  - REQ: hold mem_req_valid=1 with a stable address until mem_req_ready. On the handshake, set issued, increment iptr, and go to WAIT.
  - WAIT: on mem_resp_valid, mark the entry done, register wb_valid/wb_rob_idx/wb_dst_preg/wb_data, and go to IDLE.
  - DRAIN: absorb exactly one mem_resp_valid with no writeback, then go to IDLE. No issue occurs in DRAIN.
- Commit:
  - Applied iff commit_valid && the head entry is valid && done. Invalidates head and increments it.
  - Otherwise ignored.
- Count:
  - Dispatch and commit in the same cycle leave count unchanged.
  - When full, dispatch is refused even if a commit happens that cycle.
- Flush (priority over all other events in that cycle):
  - Clears every valid bit and sets head = tail = iptr = 0, count = 0.
  - Dispatch, address update and commit in that cycle are dropped.
  - FSM: IDLE and REQ go to IDLE (the request is withdrawn; the memory side tolerates this). WAIT goes to DRAIN. DRAIN stays in DRAIN.
- Reset: same as flush, except the FSM always goes to IDLE.
  - Outputs after reset: mem_req_valid=0, mem_req_addr=0, wb_valid=0, wb_rob_idx=0, wb_dst_preg=0, wb_data=0, lq_full=0, lq_empty=1, lq_count=0.

## Timing
- All outputs are registered except dispatch_lq_idx.
- lq_full, lq_empty and lq_count reflect the post-update state the cycle after any change (no extra lag).
- Address write at edge E → IDLE sees it in the cycle after E → mem_req_valid is high one cycle later. Minimum address-to-request latency is 2 cycles.
- Request handshake in cycle C → WAIT from C+1. mem_resp_valid may arrive as early as C+1.
- Response in cycle M → wb_valid=1 in M+1 only. The next mem_req_valid comes no earlier than M+2.
- At most one request is outstanding. Requests are issued strictly in program order.
- An entry written back in M+1 is committable from M+1.

## Test plan
- Reset mid-WAIT → outputs at the reset values above. A later stray mem_resp_valid produces no wb_valid.
- Dispatch 3 loads (rob 4, 5, 6), then addresses 0x100, 0x104, 0x108 → three requests in order at those addresses. wb_rob_idx sequence 4, 5, 6 with the response data.
- Address of entry 1 arrives before entry 0 → no request until entry 0 has its address; then order is 0 then 1.
- Fill 8 entries → lq_full=1, lq_count=8. A 9th dispatch plus a commit of an undone head → both ignored; tail wraps to 0 after the next commit.
- mem_req_ready held low 5 cycles → mem_req_valid and address stable for 5 cycles, with no iptr advance.
- Flush during WAIT, then dispatch a new load → the first response after the flush is dropped (no wb_valid). The new load issues afterwards and writes back normally.

Source files
------------

// File: rtl/load_queue.sv
// load_queue: in-order load queue beside the store queue in the memory stage.
// Allocates an entry per dispatched load and captures its address from the AGU.
// Issues one read at a time, in program order, and returns load data to writeback.
// Entries retire on ROB commit; a flush empties the queue. A response already in
// flight at flush time is absorbed by the DRAIN state.
//
// Handshakes: a memory request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high; mem_req_valid and mem_req_addr stay stable until
// then, except that a flush withdraws the request. mem_resp_valid is a single-cycle
// strobe, and at most one request is ever outstanding. wb_valid is a one-cycle pulse.
module load_queue #(
    parameter int LQ_SIZE    = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_SEL    = 6,
    parameter int PREG_SEL   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_valid,
    input  logic [ROB_SEL-1:0]         dispatch_rob_idx,
    input  logic [PREG_SEL-1:0]        dispatch_dst_preg,
    output logic [$clog2(LQ_SIZE)-1:0] dispatch_lq_idx,
    input  logic                       addr_valid,
    input  logic [$clog2(LQ_SIZE)-1:0] addr_lq_idx,
    input  logic [ADDR_WIDTH-1:0]      addr_value,
    output logic                       mem_req_valid,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_resp_data,
    output logic                       wb_valid,
    output logic [ROB_SEL-1:0]         wb_rob_idx,
    output logic [PREG_SEL-1:0]        wb_dst_preg,
    output logic [DATA_WIDTH-1:0]      wb_data,
    input  logic                       commit_valid,
    input  logic                       flush,
    output logic                       lq_full,
    output logic                       lq_empty,
    output logic [$clog2(LQ_SIZE):0]   lq_count,
    output logic [1:0]                 dbg_issue_state
);

    localparam int IDX_W = $clog2(LQ_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LQ_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } issue_state_e;

    // Entry storage
    logic [LQ_SIZE-1:0]    valid_q, addr_rdy_q, issued_q, done_q;
    logic [ROB_SEL-1:0]    rob_q  [LQ_SIZE];
    logic [PREG_SEL-1:0]   preg_q [LQ_SIZE];
    logic [ADDR_WIDTH-1:0] addr_q [LQ_SIZE];

    // Pointers and occupancy
    logic [IDX_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;

    // Issue FSM state and registered outputs
    issue_state_e          state_q, state_d;
    logic [IDX_W-1:0]      iptr_q, iptr_d;
    logic [IDX_W-1:0]      issue_idx_q, issue_idx_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [ROB_SEL-1:0]    wb_rob_q, wb_rob_d;
    logic [PREG_SEL-1:0]   wb_preg_q, wb_preg_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic dispatch_fire, addr_fire, commit_fire, issue_fire, resp_fire, issue_cand;

    // The tail entry of a non-full queue is never valid, so an address update aimed
    // at the entry being dispatched in the same cycle is dropped by the valid test.
    assign dispatch_fire = dispatch_valid && !full_q && !flush;
    assign addr_fire     = addr_valid && valid_q[addr_lq_idx] && !issued_q[addr_lq_idx] && !flush;
    assign commit_fire   = commit_valid && valid_q[head_q] && done_q[head_q] && !flush;
    assign issue_cand    = valid_q[iptr_q] && addr_rdy_q[iptr_q] && !issued_q[iptr_q];

    assign dispatch_lq_idx = tail_q;
    assign mem_req_valid   = req_valid_q;
    assign mem_req_addr    = req_addr_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rob_idx      = wb_rob_q;
    assign wb_dst_preg     = wb_preg_q;
    assign wb_data         = wb_data_q;
    assign lq_full         = full_q;
    assign lq_empty        = empty_q;
    assign lq_count        = count_q;
    assign dbg_issue_state = state_q;

    // Occupancy next state: a dispatch and a commit in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        case ({dispatch_fire, commit_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Issue FSM next state, request registers and writeback registers.
    always_comb begin
        state_d     = state_q;
        iptr_d      = iptr_q;
        issue_idx_d = issue_idx_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        wb_valid_d  = 1'b0;
        wb_rob_d    = wb_rob_q;
        wb_preg_d   = wb_preg_q;
        wb_data_d   = wb_data_q;
        issue_fire  = 1'b0;
        resp_fire   = 1'b0;
        if (flush) begin
            // Withdraw any pending request; a read already accepted must still be absorbed.
            req_valid_d = 1'b0;
            iptr_d      = '0;
            if (state_q == WAIT || state_q == DRAIN) begin
                state_d = DRAIN;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_cand) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = addr_q[iptr_q];
                        issue_idx_d = iptr_q;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        issue_fire  = 1'b1;
                        req_valid_d = 1'b0;
                        iptr_d      = iptr_q + IDX_ONE;
                        state_d     = WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        resp_fire  = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_rob_d   = rob_q[issue_idx_q];
                        wb_preg_d  = preg_q[issue_idx_q];
                        wb_data_d  = mem_resp_data;
                        state_d    = IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_resp_valid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Issue FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            iptr_q      <= '0;
            issue_idx_q <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rob_q    <= '0;
            wb_preg_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            iptr_q      <= iptr_d;
            issue_idx_q <= issue_idx_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_rob_q    <= wb_rob_d;
            wb_preg_q   <= wb_preg_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // Entry array, head/tail pointers and occupancy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            addr_rdy_q <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            for (int i = 0; i < LQ_SIZE; i++) begin
                rob_q[i]  <= '0;
                preg_q[i] <= '0;
                addr_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (dispatch_fire) begin
                valid_q[tail_q]    <= 1'b1;
                addr_rdy_q[tail_q] <= 1'b0;
                issued_q[tail_q]   <= 1'b0;
                done_q[tail_q]     <= 1'b0;
                rob_q[tail_q]      <= dispatch_rob_idx;
                preg_q[tail_q]     <= dispatch_dst_preg;
                tail_q             <= tail_q + IDX_ONE;
            end
            if (addr_fire) begin
                addr_q[addr_lq_idx]     <= addr_value;
                addr_rdy_q[addr_lq_idx] <= 1'b1;
            end
            if (issue_fire) begin
                issued_q[issue_idx_q] <= 1'b1;
            end
            if (resp_fire) begin
                done_q[issue_idx_q] <= 1'b1;
            end
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + IDX_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: tb/tb_load_queue.sv
// Bench for load_queue: directed loads with a simple read-memory responder.
// Expected requests and writebacks go into queues; a monitor compares them.
module tb_load_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dispatch_valid = 1'b0;
  logic [5:0]  dispatch_rob_idx = '0;
  logic [5:0]  dispatch_dst_preg = '0;
  logic [2:0]  dispatch_lq_idx;
  logic        addr_valid = 1'b0;
  logic [2:0]  addr_lq_idx = '0;
  logic [31:0] addr_value = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        wb_valid;
  logic [5:0]  wb_rob_idx;
  logic [5:0]  wb_dst_preg;
  logic [31:0] wb_data;
  logic        commit_valid = 1'b0;
  logic        flush = 1'b0;
  logic        lq_full;
  logic        lq_empty;
  logic [3:0]  lq_count;
  logic [1:0]  dbg_issue_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_req_q[$];
  logic [43:0] exp_wb_q[$];

  // responder controls
  logic        auto_resp = 1'b0;
  int          resp_lat = 1;
  int          force_cnt = 0;
  logic [31:0] force_data = '0;

  load_queue dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_rob_idx(dispatch_rob_idx),
    .dispatch_dst_preg(dispatch_dst_preg), .dispatch_lq_idx(dispatch_lq_idx),
    .addr_valid(addr_valid), .addr_lq_idx(addr_lq_idx), .addr_value(addr_value),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_dst_preg(wb_dst_preg), .wb_data(wb_data),
    .commit_valid(commit_valid), .flush(flush),
    .lq_full(lq_full), .lq_empty(lq_empty), .lq_count(lq_count),
    .dbg_issue_state(dbg_issue_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [43:0] wb_pack(input logic [5:0] rob, input logic [5:0] preg,
                                          input logic [31:0] data);
    return {rob, preg, data};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // memory responder: answers handshakes after resp_lat cycles when auto_resp,
  // and injects a stray response whenever force_cnt is bumped
  initial begin
    logic        hs;
    logic [31:0] hs_addr;
    logic        pend;
    logic [31:0] pend_addr;
    int          lat;
    int          served;
    pend = 1'b0; pend_addr = '0; lat = 0; served = 0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready && !reset;
      hs_addr = mem_req_addr;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (hs && auto_resp) begin
        pend = 1'b1;
        pend_addr = hs_addr;
        lat = resp_lat;
      end
      if (force_cnt != served) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = force_data;
        served++;
      end else if (pend) begin
        if (lat == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = pend_addr ^ 32'hDEAD_0000;
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req_valid && mem_req_ready) begin
          if (exp_req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: act=%0h req=none", mem_req_addr);
          end else begin
            check("req_addr", 64'(mem_req_addr), 64'(exp_req_q.pop_front()));
          end
        end
        if (wb_valid) begin
          if (exp_wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wb: act=rob %0d data %0h req=none", wb_rob_idx, wb_data);
          end else begin
            check("wb_rob_preg_data", 64'({wb_rob_idx, wb_dst_preg, wb_data}),
                  64'(exp_wb_q.pop_front()));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic dispatch(input logic [5:0] rob, input logic [5:0] preg, input logic [2:0] exp_idx);
    dispatch_valid = 1'b1;
    dispatch_rob_idx = rob;
    dispatch_dst_preg = preg;
    check("dispatch_idx", 64'(dispatch_lq_idx), 64'(exp_idx));
    tick();
    dispatch_valid = 1'b0;
  endtask

  task automatic set_addr(input logic [2:0] idx, input logic [31:0] a);
    addr_valid = 1'b1;
    addr_lq_idx = idx;
    addr_value = a;
    tick();
    addr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_occ(input string name, input logic [3:0] cnt, input logic full, input logic empty);
    check({name, "_count"}, 64'(lq_count), 64'(cnt));
    check({name, "_full"}, 64'(lq_full), 64'(full));
    check({name, "_empty"}, 64'(lq_empty), 64'(empty));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_req_valid"}, 64'(mem_req_valid), 64'(0));
    check({name, "_req_addr"}, 64'(mem_req_addr), 64'(0));
    check({name, "_wb_valid"}, 64'(wb_valid), 64'(0));
    check({name, "_wb_rob"}, 64'(wb_rob_idx), 64'(0));
    check({name, "_wb_preg"}, 64'(wb_dst_preg), 64'(0));
    check({name, "_wb_data"}, 64'(wb_data), 64'(0));
    check_occ(name, 4'd0, 1'b0, 1'b1);
  endtask

  // wait for a request handshake (bounded), return at posedge+1 after it
  task automatic wait_hs(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) seen = 1'b1;
    end
    check({name, "_handshake_seen"}, 64'(seen), 64'(1));
    tick();
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && (exp_wb_q.size() != 0 || exp_req_q.size() != 0); i++) tick();
    check({name, "_wb_left"}, 64'(exp_wb_q.size()), 64'(0));
    check({name, "_req_left"}, 64'(exp_req_q.size()), 64'(0));
  endtask

  task automatic expect_no_req(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, 64'(mem_req_valid), 64'(0));
      tick();
    end
  endtask

  // stimulus
  initial begin
    logic seen;
    // clock/reset block
    reset = 1'b1;
    wait_n(2);
    reset = 1'b0;
    check_reset_vals("por");

    // reset in the middle of WAIT, then a stray response
    auto_resp = 1'b0;
    mem_req_ready = 1'b1;
    dispatch(6'd1, 6'd2, 3'd0);
    check_occ("one", 4'd1, 1'b0, 1'b0);
    exp_req_q.push_back(32'h0000_0040);
    set_addr(3'd0, 32'h0000_0040);
    wait_hs("t1", 10);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    tick();
    reset = 1'b0;
    check_reset_vals("wait_rst");
    force_data = 32'hBAD0_BAD0;
    force_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_wb", 64'(wb_valid), 64'(0));
      tick();
    end

    // three loads in order
    auto_resp = 1'b1;
    resp_lat = 1;
    dispatch(6'd4, 6'd10, 3'd0);
    dispatch(6'd5, 6'd11, 3'd1);
    dispatch(6'd6, 6'd12, 3'd2);
    exp_req_q.push_back(32'h0000_0100);
    exp_req_q.push_back(32'h0000_0104);
    exp_req_q.push_back(32'h0000_0108);
    exp_wb_q.push_back(wb_pack(6'd4, 6'd10, 32'hDEAD_0100));
    exp_wb_q.push_back(wb_pack(6'd5, 6'd11, 32'hDEAD_0104));
    exp_wb_q.push_back(wb_pack(6'd6, 6'd12, 32'hDEAD_0108));
    set_addr(3'd0, 32'h0000_0100);
    set_addr(3'd1, 32'h0000_0104);
    set_addr(3'd2, 32'h0000_0108);
    wait_drain("t2", 80);
    check_occ("t2_pre", 4'd3, 1'b0, 1'b0);
    repeat (3) do_commit();
    check_occ("t2_post", 4'd0, 1'b0, 1'b1);

    // younger address first: no issue until the older one has its address
    dispatch(6'd7, 6'd13, 3'd3);
    dispatch(6'd8, 6'd14, 3'd4);
    set_addr(3'd4, 32'h0000_0200);
    expect_no_req("t3_blocked", 4);
    exp_req_q.push_back(32'h0000_0300);
    exp_req_q.push_back(32'h0000_0200);
    exp_wb_q.push_back(wb_pack(6'd7, 6'd13, 32'hDEAD_0300));
    exp_wb_q.push_back(wb_pack(6'd8, 6'd14, 32'hDEAD_0200));
    set_addr(3'd3, 32'h0000_0300);
    wait_drain("t3", 80);
    repeat (2) do_commit();
    check_occ("t3_post", 4'd0, 1'b0, 1'b1);

    // fill, refused dispatch plus ignored commit, wrap
    do_flush();
    for (int i = 0; i < 8; i++) dispatch(6'(16 + i), 6'(24 + i), 3'(i));
    check_occ("full", 4'd8, 1'b1, 1'b0);
    dispatch_valid = 1'b1;
    dispatch_rob_idx = 6'd50;
    dispatch_dst_preg = 6'd50;
    commit_valid = 1'b1;
    check("full_tail", 64'(dispatch_lq_idx), 64'(0));
    tick();
    dispatch_valid = 1'b0;
    commit_valid = 1'b0;
    check_occ("full_refuse", 4'd8, 1'b1, 1'b0);
    exp_req_q.push_back(32'h0000_0400);
    exp_wb_q.push_back(wb_pack(6'd16, 6'd24, 32'hDEAD_0400));
    set_addr(3'd0, 32'h0000_0400);
    wait_drain("t4", 80);
    do_commit();
    check_occ("after_commit", 4'd7, 1'b0, 1'b0);
    dispatch(6'd51, 6'd30, 3'd0);
    check_occ("refill", 4'd8, 1'b1, 1'b0);
    do_flush();
    check_occ("flush_full", 4'd0, 1'b0, 1'b1);

    // ready held low: request stable
    mem_req_ready = 1'b0;
    dispatch(6'd30, 6'd20, 3'd0);
    exp_req_q.push_back(32'h0000_0500);
    exp_wb_q.push_back(wb_pack(6'd30, 6'd20, 32'hDEAD_0500));
    set_addr(3'd0, 32'h0000_0500);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid) seen = 1'b1;
    end
    check("stall_req_seen", 64'(seen), 64'(1));
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("stall_valid", 64'(mem_req_valid), 64'(1));
      check("stall_addr", 64'(mem_req_addr), 64'(32'h0000_0500));
      check("stall_no_wb", 64'(wb_valid), 64'(0));
    end
    tick();
    mem_req_ready = 1'b1;
    wait_drain("t5", 80);
    do_commit();
    check_occ("t5_post", 4'd0, 1'b0, 1'b1);

    // flush during WAIT: the in-flight response is swallowed
    auto_resp = 1'b0;
    dispatch(6'd40, 6'd21, 3'd1);
    exp_req_q.push_back(32'h0000_0600);
    set_addr(3'd1, 32'h0000_0600);
    wait_hs("t6", 10);
    do_flush();
    check_occ("t6_flush", 4'd0, 1'b0, 1'b1);
    dispatch(6'd41, 6'd22, 3'd0);
    set_addr(3'd0, 32'h0000_0700);
    expect_no_req("drain_no_issue", 3);
    exp_req_q.push_back(32'h0000_0700);
    exp_wb_q.push_back(wb_pack(6'd41, 6'd22, 32'hDEAD_0700));
    force_data = 32'hBAD0_0600;
    force_cnt++;
    auto_resp = 1'b1;
    wait_drain("t6", 80);
    do_commit();
    check_occ("t6_post", 4'd0, 1'b0, 1'b1);

    wait_n(3);
    check("final_req_q", 64'(exp_req_q.size()), 64'(0));
    check("final_wb_q", 64'(exp_wb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
